// File: rtl/attn_score_sequencer.sv
// Batch sequencer for the 4-head x 4x4 FP32 score engine.
// Per batch: select the Q/K bank, pulse the engine start, wait for done under a watchdog,
// then drain the 64-entry score register file as a valid/ready stream to softmax.
module attn_score_sequencer #(
  parameter int unsigned NUM_SCORES  = 64,
  parameter int unsigned BATCH_W     = 4,
  parameter int unsigned TMO_W       = 20,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [BATCH_W-1:0] cfg_num_batches,
  input  logic               sw_abort,
  output logic               eng_start,
  output logic [BATCH_W-1:0] eng_bank_sel,
  input  logic               eng_done,
  output logic               score_rd_en,
  output logic [5:0]         score_rd_addr,
  input  logic [31:0]        score_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [1:0]         out_head,
  output logic [1:0]         out_row,
  output logic [1:0]         out_col,
  output logic               out_last,
  output logic [BATCH_W-1:0] out_batch,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               timeout_err
);

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SCORES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RD_ISSUE  = 3'd3,
    S_RD_CAPT   = 3'd4,
    S_OUT_HOLD  = 3'd5
  } state_t;

  state_t              r_state;
  logic [BATCH_W-1:0]  r_batch;
  logic [BATCH_W-1:0]  r_last_batch;
  logic [ADDR_W-1:0]   r_addr;
  logic [TMO_W-1:0]    r_wdog;

  logic                r_eng_start;
  logic [BATCH_W-1:0]  r_bank_sel;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [1:0]          r_out_head;
  logic [1:0]          r_out_row;
  logic [1:0]          r_out_col;
  logic                r_out_last;
  logic [BATCH_W-1:0]  r_out_batch;
  logic                r_seq_busy;
  logic                r_seq_done;
  logic                r_timeout_err;

  logic [BATCH_W-1:0]  w_cfg_last_batch;
  logic                w_addr_last;
  logic                w_batch_last;
  logic                w_accept;
  logic                w_wdog_expired;

  // A zero batch count runs a single batch; keep the index of the final batch.
  assign w_cfg_last_batch = (cfg_num_batches == '0) ? '0 : (cfg_num_batches - BATCH_W'(1));
  assign w_addr_last      = (r_addr == LAST_ADDR);
  assign w_batch_last     = (r_batch == r_last_batch);
  assign w_accept         = r_out_valid && out_ready;
  assign w_wdog_expired   = (r_wdog == TMO_LAST);

  // Sequencer FSM; every output is a register updated on entry to the state that owns it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_batch       <= '0;
      r_last_batch  <= '0;
      r_addr        <= '0;
      r_wdog        <= '0;
      r_eng_start   <= 1'b0;
      r_bank_sel    <= '0;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_head    <= '0;
      r_out_row     <= '0;
      r_out_col     <= '0;
      r_out_last    <= 1'b0;
      r_out_batch   <= '0;
      r_seq_busy    <= 1'b0;
      r_seq_done    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // Single-cycle pulses fall back low unless a transition below raises them.
      r_eng_start <= 1'b0;
      r_rd_en     <= 1'b0;
      r_seq_done  <= 1'b0;

      if (sw_abort) begin
        // Abort wins over everything; the engine keeps running and its done is ignored later.
        r_state     <= S_IDLE;
        r_out_valid <= 1'b0;
        r_seq_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cfg_start) begin
              r_state       <= S_LAUNCH;
              r_last_batch  <= w_cfg_last_batch;
              r_batch       <= '0;
              r_timeout_err <= 1'b0;
              r_eng_start   <= 1'b1;
              r_bank_sel    <= '0;
              r_seq_busy    <= 1'b1;
            end
          end

          S_LAUNCH: begin
            r_wdog  <= '0;
            r_state <= S_WAIT_DONE;
          end

          S_WAIT_DONE: begin
            if (eng_done) begin
              r_state   <= S_RD_ISSUE;
              r_addr    <= '0;
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
            end else if (w_wdog_expired) begin
              r_state       <= S_IDLE;
              r_timeout_err <= 1'b1;
              r_seq_busy    <= 1'b0;
            end else begin
              r_wdog <= r_wdog + TMO_W'(1);
            end
          end

          S_RD_ISSUE: begin
            r_state <= S_RD_CAPT;
          end

          S_RD_CAPT: begin
            // Read data is valid now, one cycle after the read enable was sampled.
            r_out_data  <= score_rd_data;
            r_out_head  <= r_addr[5:4];
            r_out_row   <= r_addr[3:2];
            r_out_col   <= r_addr[1:0];
            r_out_last  <= w_addr_last;
            r_out_batch <= r_batch;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT_HOLD;
          end

          S_OUT_HOLD: begin
            if (w_accept) begin
              r_out_valid <= 1'b0;
              if (!w_addr_last) begin
                r_addr    <= r_addr + ADDR_W'(1);
                r_rd_en   <= 1'b1;
                r_rd_addr <= r_addr + ADDR_W'(1);
                r_state   <= S_RD_ISSUE;
              end else if (!w_batch_last) begin
                r_batch     <= r_batch + BATCH_W'(1);
                r_eng_start <= 1'b1;
                r_bank_sel  <= r_batch + BATCH_W'(1);
                r_state     <= S_LAUNCH;
              end else begin
                r_seq_done <= 1'b1;
                r_seq_busy <= 1'b0;
                r_state    <= S_IDLE;
              end
            end
          end

          default: begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_seq_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign eng_start     = r_eng_start;
  assign eng_bank_sel  = r_bank_sel;
  assign score_rd_en   = r_rd_en;
  assign score_rd_addr = r_rd_addr;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_head      = r_out_head;
  assign out_row       = r_out_row;
  assign out_col       = r_out_col;
  assign out_last      = r_out_last;
  assign out_batch     = r_out_batch;
  assign seq_busy      = r_seq_busy;
  assign seq_done      = r_seq_done;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_attn_score_sequencer.sv
// Self-checking bench for attn_score_sequencer: engine model, expected-beat queue, per-cycle compare.
module tb_attn_score_sequencer;

  localparam int unsigned BATCH_W = 4;
  localparam int unsigned TMO_W   = 20;
  localparam int unsigned TMO_CYC = 50;
  localparam int          NBEAT   = 64;

  logic               clk;
  logic               rst;
  logic               cfg_start;
  logic [BATCH_W-1:0] cfg_num_batches;
  logic               sw_abort;
  logic               eng_start;
  logic [BATCH_W-1:0] eng_bank_sel;
  logic               eng_done;
  logic               score_rd_en;
  logic [5:0]         score_rd_addr;
  logic [31:0]        score_rd_data;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic [1:0]         out_head;
  logic [1:0]         out_row;
  logic [1:0]         out_col;
  logic               out_last;
  logic [BATCH_W-1:0] out_batch;
  logic               seq_busy;
  logic               seq_done;
  logic               timeout_err;

  attn_score_sequencer #(
    .NUM_SCORES (64),
    .BATCH_W    (BATCH_W),
    .TMO_W      (TMO_W),
    .TIMEOUT_CYC(TMO_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_num_batches(cfg_num_batches),
    .sw_abort       (sw_abort),
    .eng_start      (eng_start),
    .eng_bank_sel   (eng_bank_sel),
    .eng_done       (eng_done),
    .score_rd_en    (score_rd_en),
    .score_rd_addr  (score_rd_addr),
    .score_rd_data  (score_rd_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_head       (out_head),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_last       (out_last),
    .out_batch      (out_batch),
    .seq_busy       (seq_busy),
    .seq_done       (seq_done),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          addr;
    int          batch;
    bit          run_last;
  } beat_t;

  typedef struct {
    int addr;
    int head;
    int row;
    int col;
    int last;
    int batch;
    int stamp;
  } log_t;

  beat_t       exp_q[$];
  log_t        acc_log[$];
  logic [31:0] mem [0:15][0:63];

  int checks;
  int errors;
  int done_cnt;
  int n_starts;
  int cyc;
  int ready_pct;
  int stall_addr;
  int done_dly;
  bit eng_hang;
  bit spurious_done;

  // Compare state (owned by the compare process)
  bit          exp_done;
  bit          abort_check;
  bit          held;
  logic [31:0] held_data;
  logic [5:0]  held_addr;
  logic        held_last;
  logic [BATCH_W-1:0] held_batch;

  // Engine model state (owned by the engine process)
  int          eng_cnt;
  bit          rd_pend;
  int          rd_paddr;
  int          eng_bank;
  bit          prev_start;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int b = 0; b < 16; b++)
      for (int a = 0; a < NBEAT; a++)
        mem[b][a] = $urandom;
  endtask

  // Every batch drains addresses 0..63 in order; the run ends on batch n-1, addr 63.
  task automatic push_run(input int n);
    beat_t bt;
    for (int b = 0; b < n; b++) begin
      for (int a = 0; a < NBEAT; a++) begin
        bt.data     = mem[b][a];
        bt.addr     = a;
        bt.batch    = b;
        bt.run_last = (b == n - 1) && (a == NBEAT - 1);
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic start_run(input int cfg_n);
    int n;
    n = (cfg_n == 0) ? 1 : cfg_n;
    fill_mem();
    push_run(n);
    cfg_num_batches = BATCH_W'(cfg_n);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("busy_after_start", seq_busy, 1);
    check("eng_start_in_launch", eng_start, 1);
  endtask

  task automatic wait_run_done(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (done_cnt >= target) break;
    end
    check("run_complete", done_cnt, target);
  endtask

  // Engine model: done after a delay, 1-cycle-latency register file read port.
  initial begin
    eng_done      = 1'b0;
    score_rd_data = '0;
    eng_cnt       = -1;
    rd_pend       = 1'b0;
    rd_paddr      = 0;
    eng_bank      = 0;
    prev_start    = 1'b0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (!rst) begin
        eng_cnt       = -1;
        rd_pend       = 1'b0;
        prev_start    = 1'b0;
        score_rd_data = $urandom;
        continue;
      end
      if (rd_pend) score_rd_data = mem[eng_bank][rd_paddr];
      else         score_rd_data = $urandom;
      rd_pend  = score_rd_en;
      rd_paddr = int'(score_rd_addr);
      if (spurious_done) begin
        eng_done      = 1'b1;
        spurious_done = 1'b0;
      end
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done = 1'b1;
          eng_cnt  = -1;
        end
      end
      if (eng_start) begin
        check("eng_start_single_cycle", prev_start, 0);
        n_starts++;
        eng_bank = int'(eng_bank_sel);
        if (exp_q.size() > 0)  check("eng_bank_sel", eng_bank_sel, exp_q[0].batch);
        else if (eng_hang)     check("eng_bank_sel_hang", eng_bank_sel, 0);
        else                   check("eng_start_unexpected", eng_start, 0);
        if (!eng_hang) eng_cnt = (done_dly > 0) ? done_dly : int'($urandom_range(40, 3));
      end
      prev_start = eng_start;
    end
  end

  // Compare process: checks outputs every cycle against the expected-beat queue and drives out_ready.
  initial begin
    out_ready   = 1'b0;
    exp_done    = 1'b0;
    abort_check = 1'b0;
    held        = 1'b0;
    cyc         = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        exp_q.delete();
        exp_done    = 1'b0;
        abort_check = 1'b0;
        held        = 1'b0;
        out_ready   = 1'b0;
        continue;
      end
      check("seq_done", seq_done, exp_done);
      if (seq_done) begin
        done_cnt++;
        check("busy_low_at_done", seq_busy, 0);
      end
      exp_done = 1'b0;
      if (abort_check) begin
        check("abort_out_valid", out_valid, 0);
        check("abort_seq_busy", seq_busy, 0);
        check("abort_eng_start", eng_start, 0);
        check("abort_rd_en", score_rd_en, 0);
        abort_check = 1'b0;
      end
      if (out_valid) begin
        check("busy_while_valid", seq_busy, 1);
        if (exp_q.size() == 0) begin
          check("beat_unexpected", out_valid, 0);
        end else begin
          check("out_data",  out_data,  exp_q[0].data);
          check("out_head",  out_head,  exp_q[0].addr / 16);
          check("out_row",   out_row,   (exp_q[0].addr / 4) % 4);
          check("out_col",   out_col,   exp_q[0].addr % 4);
          check("out_last",  out_last,  exp_q[0].addr == NBEAT - 1);
          check("out_batch", out_batch, exp_q[0].batch);
        end
        if (held) begin
          check("hold_data",  out_data, held_data);
          check("hold_addr",  {out_head, out_row, out_col}, held_addr);
          check("hold_last",  out_last, held_last);
          check("hold_batch", out_batch, held_batch);
        end
      end else if (held) begin
        check("valid_dropped_unaccepted", out_valid, 1);
      end
      if (sw_abort) begin
        exp_q.delete();
        abort_check = 1'b1;
        held        = 1'b0;
        out_ready   = 1'b0;
        continue;
      end
      out_ready = ($urandom_range(99, 0) < ready_pct);
      if (exp_q.size() > 0 && exp_q[0].addr == stall_addr) out_ready = 1'b0;
      if (out_valid && out_ready) begin
        log_t lg;
        lg.addr  = int'({out_head, out_row, out_col});
        lg.head  = int'(out_head);
        lg.row   = int'(out_row);
        lg.col   = int'(out_col);
        lg.last  = int'(out_last);
        lg.batch = int'(out_batch);
        lg.stamp = cyc;
        acc_log.push_back(lg);
        if (exp_q.size() > 0) begin
          if (exp_q[0].run_last) exp_done = 1'b1;
          void'(exp_q.pop_front());
        end
        held = 1'b0;
      end else begin
        held       = out_valid;
        held_data  = out_data;
        held_addr  = {out_head, out_row, out_col};
        held_last  = out_last;
        held_batch = out_batch;
      end
    end
  end

  // Main stimulus
  initial begin
    int d0;
    int s0;
    bit found;
    checks          = 0;
    errors          = 0;
    done_cnt        = 0;
    n_starts        = 0;
    ready_pct       = 100;
    stall_addr      = -1;
    done_dly        = 0;
    eng_hang        = 1'b0;
    spurious_done   = 1'b0;
    rst             = 1'b0;
    cfg_start       = 1'b0;
    cfg_num_batches = '0;
    sw_abort        = 1'b0;
    fill_mem();

    // Reset state
    repeat (3) tick();
    check("rst_out_valid",   out_valid, 0);
    check("rst_eng_start",   eng_start, 0);
    check("rst_bank_sel",    eng_bank_sel, 0);
    check("rst_rd_en",       score_rd_en, 0);
    check("rst_rd_addr",     score_rd_addr, 0);
    check("rst_out_data",    out_data, 0);
    check("rst_seq_busy",    seq_busy, 0);
    check("rst_seq_done",    seq_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Single batch at full rate
    ready_pct = 100;
    acc_log.delete();
    n_starts = 0;
    d0 = done_cnt;
    start_run(1);
    wait_run_done(d0 + 1, 2000);
    check("t1_starts", n_starts, 1);
    check("t1_beats", acc_log.size(), 64);
    if (acc_log.size() == 64) begin
      for (int i = 0; i < 64; i++) check("t1_addr_order", acc_log[i].addr, i);
      check("t1_beat37_head", acc_log[37].head, 2);
      check("t1_beat37_row",  acc_log[37].row, 1);
      check("t1_beat37_col",  acc_log[37].col, 1);
      check("t1_last_on_63",  acc_log[63].last, 1);
      check("t1_last_not_62", acc_log[62].last, 0);
      check("t1_three_cycles_per_beat", acc_log[63].stamp - acc_log[0].stamp, 189);
    end
    check("t1_idle", seq_busy, 0);

    // Backpressure, two batches
    ready_pct = 30;
    d0 = done_cnt;
    start_run(2);
    wait_run_done(d0 + 1, 8000);

    // Three batches: bank and out_batch sequence, one seq_done
    ready_pct = 100;
    acc_log.delete();
    n_starts = 0;
    d0 = done_cnt;
    start_run(3);
    wait_run_done(d0 + 1, 3000);
    repeat (5) tick();
    check("t3_starts", n_starts, 3);
    check("t3_done_once", done_cnt, d0 + 1);
    check("t3_beats", acc_log.size(), 192);
    if (acc_log.size() == 192) begin
      check("t3_batch_first", acc_log[0].batch, 0);
      check("t3_batch_mid",   acc_log[64].batch, 1);
      check("t3_batch_end",   acc_log[191].batch, 2);
    end

    // Zero batch count runs one batch
    n_starts = 0;
    d0 = done_cnt;
    start_run(0);
    wait_run_done(d0 + 1, 2000);
    check("t0_starts", n_starts, 1);

    // Random runs
    for (int r = 0; r < 3; r++) begin
      ready_pct = int'($urandom_range(100, 30));
      d0 = done_cnt;
      start_run(int'($urandom_range(4, 1)));
      wait_run_done(d0 + 1, 10000);
    end

    // Watchdog timeout
    eng_hang = 1'b1;
    n_starts = 0;
    d0 = done_cnt;
    cfg_num_batches = BATCH_W'(2);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("tmo_launch", eng_start, 1);
    repeat (TMO_CYC) tick();
    check("tmo_not_yet", timeout_err, 0);
    check("tmo_busy_before", seq_busy, 1);
    tick();
    check("tmo_err_set", timeout_err, 1);
    check("tmo_idle", seq_busy, 0);
    repeat (10) tick();
    check("tmo_err_sticky", timeout_err, 1);
    check("tmo_no_done", done_cnt, d0);
    check("tmo_starts", n_starts, 1);
    eng_hang = 1'b0;
    start_run(1);
    check("tmo_err_cleared", timeout_err, 0);
    wait_run_done(d0 + 1, 2000);

    // Abort while beat 10 is stalled
    ready_pct  = 100;
    stall_addr = 10;
    d0 = done_cnt;
    start_run(1);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (out_valid && {out_head, out_row, out_col} == 6'd10) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_beat10", found, 1);
    tick();
    tick();
    check("abort_beat10_stalled", out_valid, 1);
    sw_abort = 1'b1;
    tick();
    sw_abort = 1'b0;
    check("abort_valid_next", out_valid, 0);
    check("abort_busy_next", seq_busy, 0);
    stall_addr = -1;
    repeat (5) tick();
    check("abort_no_done", done_cnt, d0);
    acc_log.delete();
    start_run(1);
    wait_run_done(d0 + 1, 2000);
    if (acc_log.size() > 0) begin
      check("restart_addr0",  acc_log[0].addr, 0);
      check("restart_batch0", acc_log[0].batch, 0);
    end

    // Abort during WAIT_DONE; the late done must be ignored
    done_dly = 20;
    d0 = done_cnt;
    n_starts = 0;
    start_run(1);
    repeat (5) tick();
    sw_abort = 1'b1;
    tick();
    sw_abort = 1'b0;
    repeat (30) tick();
    check("late_done_idle", seq_busy, 0);
    check("late_done_no_valid", out_valid, 0);
    check("late_done_no_rd", score_rd_en, 0);
    done_dly = 0;

    // cfg_start while busy is ignored
    n_starts = 0;
    d0 = done_cnt;
    start_run(2);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("busy_start_reached_drain", found, 1);
    cfg_num_batches = BATCH_W'(5);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_run_done(d0 + 1, 3000);
    repeat (10) tick();
    check("busy_start_ignored_starts", n_starts, 2);
    check("busy_start_done_once", done_cnt, d0 + 1);
    check("busy_start_idle", seq_busy, 0);

    // eng_done in IDLE is ignored
    s0 = n_starts;
    spurious_done = 1'b1;
    repeat (6) tick();
    check("idle_done_busy", seq_busy, 0);
    check("idle_done_rd", score_rd_en, 0);
    check("idle_done_starts", n_starts, s0);

    // Reset in the middle of the second batch's drain
    ready_pct = 100;
    start_run(2);
    found = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (out_valid && out_batch == BATCH_W'(1)) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_mid_reached", found, 1);
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_data",  out_data, 0);
    check("rst_mid_out_batch", out_batch, 0);
    check("rst_mid_bank_sel",  eng_bank_sel, 0);
    check("rst_mid_rd_addr",   score_rd_addr, 0);
    check("rst_mid_seq_busy",  seq_busy, 0);
    check("rst_mid_rd_en",     score_rd_en, 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    ready_pct = 60;
    d0 = done_cnt;
    start_run(1);
    wait_run_done(d0 + 1, 3000);

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
